// File: rtl/our_mem_access_logger.sv
// Passive trace logger for the 128-bit SRAM request bus: captures every access into an ordered
// FIFO, latches the tohost exit code and counts entries dropped on overflow.
module our_mem_access_logger #(
  parameter int unsigned           ADDR_WIDTH  = 21,
  parameter int unsigned           DATA_WIDTH  = 128,
  parameter int unsigned           DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 21'h1F_FFF0
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  input  logic                    log_en_i,
  input  logic                    mem_req_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH-1:0]   mem_strb_i,
  input  logic                    mem_we_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    trc_valid_o,
  input  logic                    trc_ready_i,
  output logic                    trc_we_o,
  output logic [ADDR_WIDTH-1:0]   trc_addr_o,
  output logic [DATA_WIDTH-1:0]   trc_data_o,
  output logic [DATA_WIDTH/8-1:0] trc_be_o,
  output logic                    done_o,
  output logic [30:0]             exit_code_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  output logic                    strb_err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------------------------
  // Capture stage
  // ---------------------------------------------------------------------------------------------
  logic                  w_cap_en;
  logic [BeW-1:0]        w_req_be;
  logic                  r_cap_vld;
  logic                  r_cap_we;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic [BeW-1:0]        r_cap_be;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic [DATA_WIDTH-1:0] w_ent_data;

  assign w_cap_en = mem_req_i & log_en_i;

  always_comb begin
    w_req_be = '0;
    for (int unsigned i = 0; i < BeW; i++) begin
      w_req_be[i] = mem_strb_i[8*i];
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_cap_vld  <= 1'b0;
      r_cap_we   <= 1'b0;
      r_cap_addr <= '0;
      r_cap_be   <= '0;
      r_cap_data <= '0;
    end else begin
      r_cap_vld <= w_cap_en;
      if (w_cap_en) begin
        r_cap_we   <= mem_we_i;
        r_cap_addr <= mem_addr_i;
        r_cap_be   <= mem_we_i ? w_req_be : '0;
        r_cap_data <= mem_wdata_i;
      end
    end
  end

  // Read data arrives one cycle after the request, i.e. while the entry sits in the capture stage.
  assign w_ent_data = r_cap_we ? r_cap_data : mem_rdata_i;

  // ---------------------------------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------------------------------
  logic                  r_mem_we   [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [BeW-1:0]        r_mem_be   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       w_rd_ptr_d;
  logic [CntW-1:0]       r_count;
  logic [CntW-1:0]       w_count_d;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_push_acc;
  logic                  w_drop;
  logic                  w_bypass;

  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [BeW-1:0]        w_head_be;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  r_head_we;
  logic [ADDR_WIDTH-1:0] r_head_addr;
  logic [BeW-1:0]        r_head_be;
  logic [DATA_WIDTH-1:0] r_head_data;

  assign w_full     = (r_count == CntW'(DEPTH));
  assign w_pop      = trc_valid_o & trc_ready_i;
  assign w_push     = r_cap_vld;
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  always_comb begin
    w_rd_ptr_d = r_rd_ptr + PtrW'(w_pop);
    w_count_d  = r_count;
    if (w_push_acc && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push_acc && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (w_push_acc) begin
      r_mem_we[r_wr_ptr]   <= r_cap_we;
      r_mem_addr[r_wr_ptr] <= r_cap_addr;
      r_mem_be[r_wr_ptr]   <= r_cap_be;
      r_mem_data[r_wr_ptr] <= w_ent_data;
    end
  end

  // The next head is the slot rd_ptr will point at; if that slot is being written this very
  // cycle (FIFO empty or draining its last entry) the incoming entry is forwarded instead.
  always_comb begin
    w_bypass = w_push_acc & (r_wr_ptr == w_rd_ptr_d);
    if (w_bypass) begin
      w_head_we   = r_cap_we;
      w_head_addr = r_cap_addr;
      w_head_be   = r_cap_be;
      w_head_data = w_ent_data;
    end else begin
      w_head_we   = r_mem_we[w_rd_ptr_d];
      w_head_addr = r_mem_addr[w_rd_ptr_d];
      w_head_be   = r_mem_be[w_rd_ptr_d];
      w_head_data = r_mem_data[w_rd_ptr_d];
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_head_we   <= 1'b0;
      r_head_addr <= '0;
      r_head_be   <= '0;
      r_head_data <= '0;
    end else if (w_count_d != '0) begin
      r_head_we   <= w_head_we;
      r_head_addr <= w_head_addr;
      r_head_be   <= w_head_be;
      r_head_data <= w_head_data;
    end
  end

  assign trc_valid_o = (r_count != '0);
  assign trc_we_o    = r_head_we;
  assign trc_addr_o  = r_head_addr;
  assign trc_be_o    = r_head_be;
  assign trc_data_o  = r_head_data;

  // ---------------------------------------------------------------------------------------------
  // Status: overflow, strobe check, tohost
  // ---------------------------------------------------------------------------------------------
  logic        w_strb_mixed;
  logic        w_tohost_hit;
  logic        r_overflow;
  logic [15:0] r_drop_cnt;
  logic        r_strb_err;
  logic        r_done;
  logic [30:0] r_exit_code;

  always_comb begin
    w_strb_mixed = 1'b0;
    for (int unsigned i = 0; i < BeW; i++) begin
      if (mem_strb_i[8*i +: 8] != 8'h00 && mem_strb_i[8*i +: 8] != 8'hFF) begin
        w_strb_mixed = 1'b1;
      end
    end
  end

  assign w_tohost_hit = mem_req_i & mem_we_i & (mem_addr_i == TOHOST_ADDR) &
                        mem_strb_i[0] & mem_wdata_i[0];

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_strb_err  <= 1'b0;
      r_done      <= 1'b0;
      r_exit_code <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
      if (mem_req_i && mem_we_i && w_strb_mixed) begin
        r_strb_err <= 1'b1;
      end
      // First tohost write wins until the next reset.
      if (w_tohost_hit && !r_done) begin
        r_done      <= 1'b1;
        r_exit_code <= mem_wdata_i[31:1];
      end
    end
  end

  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;
  assign strb_err_o  = r_strb_err;
  assign done_o      = r_done;
  assign exit_code_o = r_exit_code;

endmodule
